bitnet_mv_accel: RTL and testbench
==================================

// Module: bitnet_mv_accel
// PURPOSE
//  Parametrised ternary (BitNet) matrix-vector dot-product accelerator on the SoC's native valid/ready bus.
//  CPU loads DEPTH ternary weights and signed activations, then writes START.
//  Engine computes sum(a[i]*w[i]) over LEN elements, LANES per cycle, and raises a level IRQ.
//  Replaces the fixed single-element BitNet model at the 0x1001_xxxx slot.
// PARAMETERS
//  DEPTH  16  buffer entries; power of 2, 2..64
//  LANES   1  elements consumed per RUN cycle; power of 2, divides DEPTH
//  ACT_W   8  activation width, signed two's complement
//  ACC_W  24  accumulator/result width; ACT_W+log2(DEPTH) <= ACC_W <= 32
// PORTS
//  clock      in   1   sole clock, rising edge
//  reset_n    in   1   synchronous, active-low reset
//  mem_valid  in   1   bus request
//  mem_ready  out  1   one-cycle acknowledge
//  mem_addr   in   12  byte offset within block; [1:0] ignored
//  mem_wdata  in   32  write data
//  mem_wstrb  in   4   nonzero = full-word write; zero = read
//  mem_rdata  out  32  read data, valid when mem_ready=1
//  irq        out  1   level: STATUS.DONE & CTRL.IRQ_EN
//  busy       out  1   engine in RUN
// BEHAVIOUR
//  Reset: mem_ready=0, mem_rdata=0, irq=0, busy=0; CTRL/STATUS/LEN/RESULT=0, FSM=IDLE. Buffers not reset.
//  Bus: mem_valid=1 & mem_ready=0 -> mem_ready=1 next cycle for exactly 1 cycle, then 0. Master holds request until ack.
//  Map: 0x000 CTRL [0]START(W,self-clear) [1]IRQ_EN [2]ABORT(W,self-clear); 0x004 STATUS [0]DONE(W1C) [1]BUSY [2]ERR(W1C) [3]OVF(W1C)
//   0x008 LEN (write clamps to DEPTH); 0x00C RESULT (RO, sign-extended to 32)
//   0x100+4i WEIGHT[i] [1:0]: 01=+1, 11=-1, 00/10=0; 0x200+4i ACT[i] [ACT_W-1:0]. Unmapped: reads 0, writes dropped.
//  Read of WEIGHT returns stored 2 bits; of ACT returns sign-extended value.
//  FSM IDLE: acked START write -> RUN next cycle, idx=0, acc=0; LEN=0 -> DONE directly.
//  RUN: acc += sum over k<LANES of term(idx+k), terms with idx+k>=LEN forced 0; idx+=LANES;
//   when idx+LANES>=LEN -> DONE.
//  DONE (1 cycle): RESULT<=acc, STATUS.DONE<=1 -> IDLE.
//  Latency: STATUS.DONE visible ceil(LEN/LANES)+2 cycles after START ack (LEN=0: 2 cycles).
//  Arithmetic: products are +a, -a or 0, sign-extended to ACC_W; sum wraps modulo 2^ACC_W.
//  While busy: WEIGHT/ACT/LEN writes dropped, ERR<=1; START ignored, ERR<=1; reads served normally.
//  ABORT in RUN: -> IDLE next cycle, RESULT and DONE unchanged; ABORT in IDLE is a no-op.
//  Same-cycle DONE set and W1C clear: set wins.
//  reset_n low mid-RUN: full reset values next edge; in-flight computation discarded.
// CONFIGURATION
//  BITNET_MV_SAT_EN defined: each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//   Any clip sets STATUS.OVF.
//  Undefined: wrap-around arithmetic; OVF reads 0.
// TESTING
//  Reset: hold reset_n=0 3 cycles -> irq=0, busy=0; reads of CTRL/STATUS/LEN/RESULT return 0.
//  Basic: LEN=4, W={+1,-1,0,+1}, A={10,3,7,-5}, IRQ_EN=1, START -> RESULT=2, irq=1.
//   DONE at cycle ack+6 (LANES=1) and ack+4 (LANES=2).
//  Empty: LEN=0, START -> DONE at ack+2, RESULT=0; W1C STATUS=1 -> irq=0.
//  Busy protection: LEN=16, START; write ACT[0]=99 while busy -> ACT[0] unchanged, ERR=1.
//   Second START dropped; RESULT from original data.
//  Overflow: ACC_W=10, LEN=16, all W=+1, A=127.
//   Without macro -> RESULT=-16 (0xFFFFFFF0). With BITNET_MV_SAT_EN -> RESULT=511, OVF=1.
//  Abort/reset: ABORT at RUN cycle 3 -> busy=0 next cycle, DONE=0, RESULT unchanged.
//   Repeat with reset_n=0 instead -> all registers 0.

Source files
------------

// File: rtl/bitnet_mv_accel_if.sv
// Native valid/ready memory bus used by the BitNet matrix-vector accelerator.
// The master drives a request and holds it until mem_ready; the slave acks for one cycle.
interface bitnet_mv_accel_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/bitnet_mv_accel.sv
// Ternary (BitNet) dot-product engine: sum(a[i]*w[i]) over LEN entries, LANES per cycle.
// Optional feature macro: BITNET_MV_SAT_EN -- saturating accumulation with sticky STATUS.OVF.
// Without it the accumulator wraps modulo 2^ACC_W and OVF always reads 0.
module bitnet_mv_accel #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LANES = 1,
    parameter int unsigned ACT_W = 8,
    parameter int unsigned ACC_W = 24
) (
    input  logic             clock,
    input  logic             reset_n,
    bitnet_mv_accel_if.slave bus,
    output logic             irq,
    output logic             busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Length/index width must hold DEPTH itself
    localparam int unsigned LW = AW + 1;
    // Headroom so an accumulate step never overflows before clipping/wrapping
    localparam int unsigned SW = ACC_W + $clog2(LANES) + 2;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                   state_q, state_d;
    logic                     ready_q;
    logic [31:0]              rdata_q, rd_val;
    logic                     irq_en_q, done_q, err_q, ovf_q;
    logic [LW-1:0]            len_q, idx_q, len_wr, pos;
    logic [ACC_W-1:0]         acc_q, acc_next, result_q;
    logic signed [SW-1:0]     lane_sum, sum_ext;
    logic                     clip;
    logic [1:0]               wgt_q [DEPTH];
    logic [ACT_W-1:0]         act_q [DEPTH];

    logic                     access, wr_en, running, run_last;
    logic [3:0]               region;
    logic [5:0]               off;
    logic                     in_buf;
    logic [AW-1:0]            buf_idx;
    logic                     wr_ctrl, wr_status, wr_len, wr_wgt, wr_act;
    logic                     start_req, abort_req, err_set;
    logic                     unused_bits;

    // Request is accepted on the edge that raises mem_ready; writes commit at the end of the ack.
    assign access  = bus.mem_valid & ~ready_q;
    assign wr_en   = bus.mem_valid & ready_q & (|bus.mem_wstrb);
    assign running = (state_q == StRun);

    assign region  = bus.mem_addr[11:8];
    assign off     = bus.mem_addr[7:2];
    assign in_buf  = (32'(off) < DEPTH);
    assign buf_idx = off[AW-1:0];

    assign wr_ctrl   = wr_en && (region == 4'h0) && (off == 6'd0);
    assign wr_status = wr_en && (region == 4'h0) && (off == 6'd1);
    assign wr_len    = wr_en && (region == 4'h0) && (off == 6'd2);
    assign wr_wgt    = wr_en && (region == 4'h1) && in_buf;
    assign wr_act    = wr_en && (region == 4'h2) && in_buf;

    assign start_req = wr_ctrl & bus.mem_wdata[0] & ~running;
    assign abort_req = wr_ctrl & bus.mem_wdata[2] & running;
    assign err_set   = running & ((wr_ctrl & bus.mem_wdata[0]) | wr_len | wr_wgt | wr_act);

    assign len_wr   = (bus.mem_wdata > 32'(DEPTH)) ? LW'(DEPTH) : bus.mem_wdata[LW-1:0];
    assign run_last = ((idx_q + LW'(LANES)) >= len_q);

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;

    assign unused_bits = ^{bus.mem_addr[1:0], sum_ext};

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_req) state_d = (len_q == '0) ? StDone : StRun;
            end
            StRun: begin
                if (abort_req)     state_d = StIdle;
                else if (run_last) state_d = StDone;
            end
            StDone: begin
                if (start_req) state_d = (len_q == '0) ? StDone : StRun;
                else           state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = running;
        irq  = done_q & irq_en_q;
    end

    // Sum of this cycle's ternary products; lanes past LEN contribute nothing
    always_comb begin
        lane_sum = '0;
        pos      = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            pos = idx_q + LW'(k);
            if (pos < len_q) begin
                case (wgt_q[pos[AW-1:0]])
                    2'b01:   lane_sum = lane_sum + SW'($signed(act_q[pos[AW-1:0]]));
                    2'b11:   lane_sum = lane_sum - SW'($signed(act_q[pos[AW-1:0]]));
                    default: ;
                endcase
            end
        end
    end

    // Accumulate step: saturating or wrapping depending on build
    always_comb begin
        sum_ext = SW'($signed(acc_q)) + lane_sum;
`ifdef BITNET_MV_SAT_EN
        if (sum_ext > $signed({{(SW - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}})) begin
            acc_next = {1'b0, {(ACC_W - 1){1'b1}}};
            clip     = 1'b1;
        end else if (sum_ext < $signed({{(SW - ACC_W + 1){1'b1}}, {(ACC_W - 1){1'b0}}})) begin
            acc_next = {1'b1, {(ACC_W - 1){1'b0}}};
            clip     = 1'b1;
        end else begin
            acc_next = sum_ext[ACC_W-1:0];
            clip     = 1'b0;
        end
`else
        acc_next = sum_ext[ACC_W-1:0];
        clip     = 1'b0;
`endif
    end

    // Engine index and accumulator
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            idx_q <= '0;
            acc_q <= '0;
        end else if (start_req) begin
            idx_q <= '0;
            acc_q <= '0;
        end else if (running) begin
            idx_q <= idx_q + LW'(LANES);
            acc_q <= acc_next;
        end
    end

    // Control/status registers; a DONE set in the same cycle as its W1C clear wins
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            len_q    <= '0;
            result_q <= '0;
        end else begin
            if (wr_ctrl) irq_en_q <= bus.mem_wdata[1];
            if (wr_len && !running) len_q <= len_wr;
            if (state_q == StDone) result_q <= acc_q;
            done_q <= (state_q == StDone) | (done_q & ~(wr_status & bus.mem_wdata[0]));
            err_q  <= err_set | (err_q & ~(wr_status & bus.mem_wdata[2]));
            ovf_q  <= (running & clip) | (ovf_q & ~(wr_status & bus.mem_wdata[3]));
        end
    end

    // Operand buffers (not reset); frozen while the engine runs
    always_ff @(posedge clock) begin
        if (wr_wgt && !running) wgt_q[buf_idx] <= bus.mem_wdata[1:0];
        if (wr_act && !running) act_q[buf_idx] <= bus.mem_wdata[ACT_W-1:0];
    end

    // Read-data mux
    always_comb begin
        rd_val = '0;
        case (region)
            4'h0: begin
                case (off)
                    6'd0:    rd_val = {30'd0, irq_en_q, 1'b0};
                    6'd1:    rd_val = {28'd0, ovf_q, err_q, running, done_q};
                    6'd2:    rd_val = 32'(len_q);
                    6'd3:    rd_val = 32'($signed(result_q));
                    default: ;
                endcase
            end
            4'h1:    if (in_buf) rd_val = {30'd0, wgt_q[buf_idx]};
            4'h2:    if (in_buf) rd_val = 32'($signed(act_q[buf_idx]));
            default: ;
        endcase
    end

    // One-cycle acknowledge with registered read data
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= access;
            rdata_q <= (access && (bus.mem_wstrb == 4'b0)) ? rd_val : '0;
        end
    end

endmodule

// File: tb/tb_bitnet_mv_accel.sv
// Scoreboard bench for bitnet_mv_accel: dut0 (LANES=1, ACC_W=24), dut1 (LANES=2, ACC_W=10).
module tb_bitnet_mv_accel;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    bitnet_mv_accel_if bus0 ();
    bitnet_mv_accel_if bus1 ();

    logic        m_valid [2];
    logic [11:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wstrb [2];
    logic        irq0, busy0, irq1, busy1;

    assign bus0.mem_valid = m_valid[0];
    assign bus0.mem_addr  = m_addr[0];
    assign bus0.mem_wdata = m_wdata[0];
    assign bus0.mem_wstrb = m_wstrb[0];
    assign bus1.mem_valid = m_valid[1];
    assign bus1.mem_addr  = m_addr[1];
    assign bus1.mem_wdata = m_wdata[1];
    assign bus1.mem_wstrb = m_wstrb[1];

    bitnet_mv_accel #(.DEPTH(16), .LANES(1), .ACT_W(8), .ACC_W(24)) dut0 (
        .clock(clock), .reset_n(reset_n), .bus(bus0), .irq(irq0), .busy(busy0)
    );

    bitnet_mv_accel #(.DEPTH(16), .LANES(2), .ACT_W(8), .ACC_W(10)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(bus1), .irq(irq1), .busy(busy1)
    );

`ifdef BITNET_MV_SAT_EN
    localparam logic [31:0] OVF_RESULT = 32'd511;
    localparam logic [31:0] OVF_STATUS = 32'h9;
`else
    localparam logic [31:0] OVF_RESULT = 32'hFFFF_FFF0;
    localparam logic [31:0] OVF_STATUS = 32'h1;
`endif

    typedef struct {
        bit          chk;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    // Basic vector: 10 - 3 + 0 - 5 = 2
    logic [1:0] bw [4] = '{2'b01, 2'b11, 2'b00, 2'b01};
    logic [7:0] ba [4] = '{8'd10, 8'd3, 8'd7, 8'hFB};

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endfunction

    function automatic logic ready_of(input int inst);
        return (inst != 0) ? bus1.mem_ready : bus0.mem_ready;
    endfunction

    function automatic logic irq_of(input int inst);
        return (inst != 0) ? irq1 : irq0;
    endfunction

    // Monitors: pop expected read data whenever a DUT acknowledges
    always @(negedge clock) begin : mon0
        exp_t e;
        if (bus0.mem_ready) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0_unexpected_ack: got ack expected none");
            end else begin
                e = q0.pop_front();
                if (e.chk) check(e.name, bus0.mem_rdata, e.data);
            end
        end
    end

    always @(negedge clock) begin : mon1
        exp_t e;
        if (bus1.mem_ready) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected_ack: got ack expected none");
            end else begin
                e = q1.pop_front();
                if (e.chk) check(e.name, bus1.mem_rdata, e.data);
            end
        end
    end

    task automatic xfer(input int inst, input logic [11:0] addr, input logic [31:0] wd,
                        input bit wr, input logic [31:0] expv, input string name);
        exp_t e;
        bit   got;
        e.chk  = !wr;
        e.data = expv;
        e.name = name;
        if (inst != 0) q1.push_back(e);
        else           q0.push_back(e);
        @(negedge clock);
        m_valid[inst] = 1'b1;
        m_addr[inst]  = addr;
        m_wdata[inst] = wd;
        m_wstrb[inst] = wr ? 4'hF : 4'h0;
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clock);
            if (ready_of(inst)) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: no ack within 8 cycles, ack required", name);
        end
        // Hold through the ack edge, then release
        @(posedge clock);
        #1;
        m_valid[inst] = 1'b0;
        m_wstrb[inst] = 4'h0;
    endtask

    task automatic wr(input int inst, input logic [11:0] addr, input logic [31:0] wd);
        xfer(inst, addr, wd, 1'b1, 32'h0, "write");
    endtask

    task automatic rd(input int inst, input logic [11:0] addr, input logic [31:0] expv,
                      input string name);
        xfer(inst, addr, 32'h0, 1'b0, expv, name);
    endtask

    // Counts negedges from the cycle after the ack until irq rises
    task automatic wait_irq(input int inst, output int cnt);
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
        end while (!irq_of(inst) && cnt < 200);
        if (!irq_of(inst)) begin
            checks++;
            errors++;
            $display("FAIL irq_wait: irq=0 after %0d cycles, irq=1 required", cnt);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, finish required");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cnt;
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0;
            m_addr[i]  = '0;
            m_wdata[i] = '0;
            m_wstrb[i] = '0;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_irq", 32'(irq0), 32'h0);
        check("reset_busy", 32'(busy0), 32'h0);
        reset_n = 1'b1;
        rd(0, 12'h000, 32'h0, "reset_ctrl");
        rd(0, 12'h004, 32'h0, "reset_status");
        rd(0, 12'h008, 32'h0, "reset_len");
        rd(0, 12'h00C, 32'h0, "reset_result");

        // Basic dot product, LANES=1
        wr(0, 12'h008, 32'd4);
        for (int i = 0; i < 4; i++) begin
            wr(0, 12'h100 + 12'(4 * i), 32'(bw[i]));
            wr(0, 12'h200 + 12'(4 * i), 32'(ba[i]));
        end
        wr(0, 12'h000, 32'h3);
        wait_irq(0, cnt);
        check("basic_latency", 32'(cnt), 32'd6);
        check("basic_irq", 32'(irq0), 32'h1);
        rd(0, 12'h00C, 32'd2, "basic_result");
        rd(0, 12'h004, 32'h1, "basic_status");
        rd(0, 12'h104, 32'h3, "weight1_readback");
        rd(0, 12'h20C, 32'hFFFF_FFFB, "act3_signext");
        wr(0, 12'h004, 32'h1);
        check("w1c_irq_clear", 32'(irq0), 32'h0);

        // Empty vector
        wr(0, 12'h008, 32'd0);
        wr(0, 12'h000, 32'h3);
        wait_irq(0, cnt);
        check("empty_latency", 32'(cnt), 32'd2);
        rd(0, 12'h00C, 32'd0, "empty_result");
        wr(0, 12'h004, 32'h1);
        check("empty_irq_clear", 32'(irq0), 32'h0);

        // LEN clamps to DEPTH
        wr(0, 12'h008, 32'd100);
        rd(0, 12'h008, 32'd16, "len_clamp");

        // Busy protection: 1+2+...+16 = 136
        for (int i = 0; i < 16; i++) begin
            wr(0, 12'h100 + 12'(4 * i), 32'h1);
            wr(0, 12'h200 + 12'(4 * i), 32'(i + 1));
        end
        wr(0, 12'h000, 32'h3);
        check("busy_run", 32'(busy0), 32'h1);
        wr(0, 12'h200, 32'd99);
        wr(0, 12'h000, 32'h3);
        wait_irq(0, cnt);
        rd(0, 12'h200, 32'd1, "busy_act_kept");
        rd(0, 12'h004, 32'h5, "busy_status_err");
        rd(0, 12'h00C, 32'd136, "busy_result");
        wr(0, 12'h004, 32'hF);
        check("busy_irq_clear", 32'(irq0), 32'h0);

        // Unmapped space
        rd(0, 12'h010, 32'h0, "unmapped_ctrl_page");
        rd(0, 12'h300, 32'h0, "unmapped_page3");
        rd(0, 12'h150, 32'h0, "weight_past_depth");

        // Abort mid-run
        wr(0, 12'h000, 32'h3);
        repeat (2) @(negedge clock);
        wr(0, 12'h000, 32'h6);
        check("abort_busy", 32'(busy0), 32'h0);
        rd(0, 12'h004, 32'h0, "abort_status");
        rd(0, 12'h00C, 32'd136, "abort_result");
        check("abort_irq", 32'(irq0), 32'h0);

        // LANES=2 instance: latency and wrap/saturate
        wr(1, 12'h008, 32'd4);
        for (int i = 0; i < 4; i++) begin
            wr(1, 12'h100 + 12'(4 * i), 32'(bw[i]));
            wr(1, 12'h200 + 12'(4 * i), 32'(ba[i]));
        end
        wr(1, 12'h000, 32'h3);
        wait_irq(1, cnt);
        check("lanes2_latency", 32'(cnt), 32'd4);
        rd(1, 12'h00C, 32'd2, "lanes2_result");
        wr(1, 12'h004, 32'hF);
        check("lanes2_irq_clear", 32'(irq1), 32'h0);
        wr(1, 12'h008, 32'd16);
        for (int i = 0; i < 16; i++) begin
            wr(1, 12'h100 + 12'(4 * i), 32'h1);
            wr(1, 12'h200 + 12'(4 * i), 32'd127);
        end
        wr(1, 12'h000, 32'h3);
        wait_irq(1, cnt);
        rd(1, 12'h00C, OVF_RESULT, "ovf_result");
        rd(1, 12'h004, OVF_STATUS, "ovf_status");

        // Reset mid-run on dut0
        wr(0, 12'h000, 32'h3);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("rst_busy", 32'(busy0), 32'h0);
        check("rst_irq1", 32'(irq1), 32'h0);
        rd(0, 12'h000, 32'h0, "rst_ctrl");
        rd(0, 12'h004, 32'h0, "rst_status");
        rd(0, 12'h008, 32'h0, "rst_len");
        rd(0, 12'h00C, 32'h0, "rst_result");

        repeat (4) @(negedge clock);
        check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
